// File: rtl/vector_cache_pkg.sv
// Shared types and helpers for the vector-cache xy injection path.
// Holds the injection source encoding and the 3-way round-robin pick function.
package vector_cache_pkg;

  typedef enum logic [1:0] {
    INJ_WEST  = 2'd0,
    INJ_NORTH = 2'd1,
    INJ_SOUTH = 2'd2
  } inj_src_e;

  localparam int VEC_CACHE_INJ_CREDIT = 4;

  // Returns a one-hot grant: first set request searching from ptr, ptr+1, ptr+2 (mod 3).
  function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
    logic [2:0] gnt;
    gnt = 3'b000;
    case (ptr)
      2'd1:    gnt = req[1] ? 3'b010 : req[2] ? 3'b100 : req[0] ? 3'b001 : 3'b000;
      2'd2:    gnt = req[2] ? 3'b100 : req[0] ? 3'b001 : req[1] ? 3'b010 : 3'b000;
      default: gnt = req[0] ? 3'b001 : req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000;
    endcase
    return gnt;
  endfunction

  function automatic inj_src_e gnt_to_src(input logic [2:0] gnt);
    inj_src_e src;
    src = INJ_WEST;
    if (gnt[1]) src = INJ_NORTH;
    else if (gnt[2]) src = INJ_SOUTH;
    return src;
  endfunction

endpackage

// File: rtl/vec_cache_rr_arb3.sv
// Three-way round-robin arbiter with a registered priority pointer.
// The pointer moves to the source after the winner, so the winner becomes lowest priority.
module vec_cache_rr_arb3
  import vector_cache_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       en,
  output logic [2:0] gnt
);

  logic [1:0] ptr;

  assign gnt = en ? rr_pick(req, ptr) : 3'b000;

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 2'd0;
    end else if (gnt[0]) begin
      ptr <= 2'd1;
    end else if (gnt[1]) begin
      ptr <= 2'd2;
    end else if (gnt[2]) begin
      ptr <= 2'd0;
    end
  end

endmodule

// File: rtl/vec_cache_xy_inj_arbiter.sv
// Per-channel injection arbiter ahead of a diagonal xy switch block: one credit-gated
// round-robin grant per channel per cycle, presented to the switch as a registered injection.
module vec_cache_xy_inj_arbiter
  import vector_cache_pkg::*;
#(
  parameter  int CH_NUM     = 8,
  parameter  int PLD_W      = 512,
  parameter  int CREDIT_NUM = VEC_CACHE_INJ_CREDIT,
  localparam int CW         = $clog2(CREDIT_NUM + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cfg_en,
  input  logic [CH_NUM-1:0][2:0]              req_vld,
  input  logic [CH_NUM-1:0][2:0][PLD_W-1:0]   req_pld,
  output logic [CH_NUM-1:0][2:0]              req_rdy,
  output logic [CH_NUM-1:0]                   out_vld,
  output logic [CH_NUM-1:0][PLD_W-1:0]        out_pld,
  output logic [CH_NUM-1:0][1:0]              out_src,
  input  logic [CH_NUM-1:0]                   crd_rtn,
  output logic [CH_NUM-1:0][CW-1:0]           crd_cnt,
  output logic [CH_NUM-1:0]                   crd_ovf_err
);

  localparam logic [CW-1:0] CNT_MAX = CW'(CREDIT_NUM);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    logic [2:0]       gnt;
    logic             grant;
    logic             eligible;
    logic [PLD_W-1:0] pld_sel;
    logic             vld_q;
    logic [PLD_W-1:0] pld_q;
    inj_src_e         src_q;
    logic [CW-1:0]    cnt_q;
    logic             ovf_q;

    // Only the registered count gates grants; a same-cycle return is not bypassed.
    assign eligible = cfg_en && (cnt_q != '0) && !rst;

    vec_cache_rr_arb3 u_arb (
      .clk (clk),
      .rst (rst),
      .req (req_vld[c]),
      .en  (eligible),
      .gnt (gnt)
    );

    assign grant = |gnt;

    // NOTE: combinational blocks assign a default first so no path leaves a latch behind.
    always_comb begin
      pld_sel = req_pld[c][0];
      if (gnt[1]) pld_sel = req_pld[c][1];
      else if (gnt[2]) pld_sel = req_pld[c][2];
    end

    // NOTE: the wide payload register is reset deliberately so the switch never sees stale data.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= 1'b0;
        pld_q <= '0;
        src_q <= INJ_WEST;
      end else begin
        vld_q <= grant;
        if (grant) begin
          pld_q <= pld_sel;
          src_q <= gnt_to_src(gnt);
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= CNT_MAX;
        ovf_q <= 1'b0;
      end else begin
        case ({grant, crd_rtn[c]})
          2'b10: cnt_q <= cnt_q - CNT_ONE;
          2'b01: begin
            if (cnt_q == CNT_MAX) ovf_q <= 1'b1;
            else cnt_q <= cnt_q + CNT_ONE;
          end
          default: ;
        endcase
      end
    end

    assign req_rdy[c]     = gnt;
    assign out_vld[c]     = vld_q;
    assign out_pld[c]     = pld_q;
    assign out_src[c]     = src_q;
    assign crd_cnt[c]     = cnt_q;
    assign crd_ovf_err[c] = ovf_q;
  end

endmodule

// File: tb/tb_vec_cache_xy_inj_arbiter.sv
// Directed bench for vec_cache_xy_inj_arbiter: one task per scenario with inline checks.
module tb_vec_cache_xy_inj_arbiter;

  localparam int CH_NUM = 8;
  localparam int PLD_W  = 512;
  localparam int CW     = 3;

  logic                              clk;
  logic                              rst;
  logic                              cfg_en;
  logic [CH_NUM-1:0][2:0]            req_vld;
  logic [CH_NUM-1:0][2:0][PLD_W-1:0] req_pld;
  logic [CH_NUM-1:0][2:0]            req_rdy;
  logic [CH_NUM-1:0]                 out_vld;
  logic [CH_NUM-1:0][PLD_W-1:0]      out_pld;
  logic [CH_NUM-1:0][1:0]            out_src;
  logic [CH_NUM-1:0]                 crd_rtn;
  logic [CH_NUM-1:0][CW-1:0]         crd_cnt;
  logic [CH_NUM-1:0]                 crd_ovf_err;

  int total = 0;
  int bad   = 0;

  vec_cache_xy_inj_arbiter #(
    .CH_NUM     (CH_NUM),
    .PLD_W      (PLD_W),
    .CREDIT_NUM (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_en      (cfg_en),
    .req_vld     (req_vld),
    .req_pld     (req_pld),
    .req_rdy     (req_rdy),
    .out_vld     (out_vld),
    .out_pld     (out_pld),
    .out_src     (out_src),
    .crd_rtn     (crd_rtn),
    .crd_cnt     (crd_cnt),
    .crd_ovf_err (crd_ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    cfg_en  = 1'b1;
    req_vld = '0;
    req_pld = '0;
    crd_rtn = '0;
    #3;
    req_vld[0] = 3'b111;
    #1;
    total++;
    if (req_rdy !== '0) begin bad++; $display("FAIL reset_rdy got=%h exp=0", req_rdy); end
    total++;
    if (out_vld !== '0) begin bad++; $display("FAIL reset_vld got=%h exp=0", out_vld); end
    total++;
    if (out_pld !== '0) begin bad++; $display("FAIL reset_pld got nonzero exp=0"); end
    total++;
    if (out_src !== '0) begin bad++; $display("FAIL reset_src got=%h exp=0", out_src); end
    total++;
    if (crd_cnt !== {CH_NUM{3'd4}}) begin bad++; $display("FAIL reset_cnt got=%h exp=all 4", crd_cnt); end
    total++;
    if (crd_ovf_err !== '0) begin bad++; $display("FAIL reset_ovf got=%h exp=0", crd_ovf_err); end
    req_vld = '0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_west();
    req_vld[0][0] = 1'b1;
    req_pld[0][0] = PLD_W'(8'hA5);
    #1;
    total++;
    if (req_rdy[0] !== 3'b001) begin bad++; $display("FAIL t1_rdy got=%b exp=001", req_rdy[0]); end
    step();
    req_vld[0][0] = 1'b0;
    total++;
    if (out_vld[0] !== 1'b1) begin bad++; $display("FAIL t1_vld got=%b exp=1", out_vld[0]); end
    total++;
    if (out_pld[0] !== PLD_W'(8'hA5)) begin bad++; $display("FAIL t1_pld got=%h exp=a5", out_pld[0][7:0]); end
    total++;
    if (out_src[0] !== 2'd0) begin bad++; $display("FAIL t1_src got=%0d exp=0", out_src[0]); end
    total++;
    if (crd_cnt[0] !== 3'd3) begin bad++; $display("FAIL t1_cnt got=%0d exp=3", crd_cnt[0]); end
    step();
    total++;
    if (out_vld[0] !== 1'b0) begin bad++; $display("FAIL t1_idle_vld got=%b exp=0", out_vld[0]); end
    total++;
    if (out_pld[0] !== PLD_W'(8'hA5)) begin bad++; $display("FAIL t1_hold_pld got=%h exp=a5", out_pld[0][7:0]); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_gnt [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [1:0] exp_src [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    req_pld[3][0] = PLD_W'(8'h30);
    req_pld[3][1] = PLD_W'(8'h31);
    req_pld[3][2] = PLD_W'(8'h32);
    req_vld[3]    = 3'b111;
    crd_rtn[3]    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      total++;
      if (req_rdy[3] !== exp_gnt[i]) begin bad++; $display("FAIL t2_rdy[%0d] got=%b exp=%b", i, req_rdy[3], exp_gnt[i]); end
      step();
      total++;
      if (out_vld[3] !== 1'b1) begin bad++; $display("FAIL t2_vld[%0d] got=%b exp=1", i, out_vld[3]); end
      total++;
      if (out_src[3] !== exp_src[i]) begin bad++; $display("FAIL t2_src[%0d] got=%0d exp=%0d", i, out_src[3], exp_src[i]); end
      total++;
      if (out_pld[3] !== PLD_W'(8'h30 + exp_src[i])) begin bad++; $display("FAIL t2_pld[%0d] got=%h", i, out_pld[3][7:0]); end
      total++;
      if (crd_cnt[3] !== 3'd4) begin bad++; $display("FAIL t2_cnt[%0d] got=%0d exp=4", i, crd_cnt[3]); end
    end
    req_vld[3] = 3'b000;
    crd_rtn[3] = 1'b0;
    step();
  endtask

  task automatic test_credit_exhaust();
    req_vld[1][1] = 1'b1;
    req_pld[1][1] = PLD_W'(8'h11);
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (req_rdy[1] !== 3'b010) begin bad++; $display("FAIL t3_rdy[%0d] got=%b exp=010", i, req_rdy[1]); end
      step();
      total++;
      if (out_vld[1] !== 1'b1) begin bad++; $display("FAIL t3_vld[%0d] got=%b exp=1", i, out_vld[1]); end
      total++;
      if (crd_cnt[1] !== 3'(3 - i)) begin bad++; $display("FAIL t3_cnt[%0d] got=%0d exp=%0d", i, crd_cnt[1], 3 - i); end
    end
    #1;
    total++;
    if (req_rdy[1] !== 3'b000) begin bad++; $display("FAIL t3_empty_rdy got=%b exp=000", req_rdy[1]); end
    step();
    total++;
    if (out_vld[1] !== 1'b0) begin bad++; $display("FAIL t3_empty_vld got=%b exp=0", out_vld[1]); end
    crd_rtn[1] = 1'b1;
    #1;
    total++;
    if (req_rdy[1] !== 3'b000) begin bad++; $display("FAIL t3_no_bypass got=%b exp=000", req_rdy[1]); end
    step();
    crd_rtn[1] = 1'b0;
    total++;
    if (crd_cnt[1] !== 3'd1) begin bad++; $display("FAIL t3_rtn_cnt got=%0d exp=1", crd_cnt[1]); end
    #1;
    total++;
    if (req_rdy[1] !== 3'b010) begin bad++; $display("FAIL t3_regrant got=%b exp=010", req_rdy[1]); end
    step();
    total++;
    if (out_vld[1] !== 1'b1 || crd_cnt[1] !== 3'd0) begin
      bad++; $display("FAIL t3_regrant_out vld=%b cnt=%0d exp vld=1 cnt=0", out_vld[1], crd_cnt[1]);
    end
    #1;
    total++;
    if (req_rdy[1] !== 3'b000) begin bad++; $display("FAIL t3_only_one got=%b exp=000", req_rdy[1]); end
    req_vld[1][1] = 1'b0;
    step();
  endtask

  task automatic test_overflow();
    crd_rtn[2] = 1'b1;
    step();
    crd_rtn[2] = 1'b0;
    total++;
    if (crd_ovf_err !== 8'b0000_0100) begin bad++; $display("FAIL t4_ovf got=%b exp=00000100", crd_ovf_err); end
    total++;
    if (crd_cnt[2] !== 3'd4) begin bad++; $display("FAIL t4_cnt got=%0d exp=4", crd_cnt[2]); end
    step();
    step();
    total++;
    if (crd_ovf_err[2] !== 1'b1) begin bad++; $display("FAIL t4_sticky got=%b exp=1", crd_ovf_err[2]); end
    total++;
    if (crd_cnt[2] !== 3'd4) begin bad++; $display("FAIL t4_cnt_hold got=%0d exp=4", crd_cnt[2]); end
  endtask

  task automatic test_cfg_disable();
    cfg_en        = 1'b0;
    req_vld[4][2] = 1'b1;
    req_pld[4][2] = PLD_W'(8'h44);
    for (int i = 0; i < 10; i++) begin
      #1;
      total++;
      if (req_rdy[4] !== 3'b000) begin bad++; $display("FAIL t5_rdy[%0d] got=%b exp=000", i, req_rdy[4]); end
      step();
      total++;
      if (out_vld[4] !== 1'b0) begin bad++; $display("FAIL t5_vld[%0d] got=%b exp=0", i, out_vld[4]); end
    end
    cfg_en = 1'b1;
    #1;
    total++;
    if (req_rdy[4] !== 3'b100) begin bad++; $display("FAIL t5_en_rdy got=%b exp=100", req_rdy[4]); end
    step();
    req_vld[4][2] = 1'b0;
    total++;
    if (out_vld[4] !== 1'b1 || out_src[4] !== 2'd2 || out_pld[4] !== PLD_W'(8'h44)) begin
      bad++; $display("FAIL t5_out vld=%b src=%0d pld=%h exp vld=1 src=2 pld=44", out_vld[4], out_src[4], out_pld[4][7:0]);
    end
    step();
  endtask

  task automatic test_reset_mid_traffic();
    crd_rtn[1] = 1'b1;
    step();
    crd_rtn[1] = 1'b0;
    for (int c = 0; c < CH_NUM; c++) begin
      for (int s = 0; s < 3; s++) req_pld[c][s] = PLD_W'(16'h8000 + c * 16 + s);
    end
    req_vld = {CH_NUM{3'b111}};
    step();
    total++;
    if (out_vld !== 8'hFF) begin bad++; $display("FAIL t6_pre_vld got=%h exp=ff", out_vld); end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (out_vld !== '0 || out_pld !== '0 || out_src !== '0) begin
      bad++; $display("FAIL t6_async_out vld=%h src=%h exp all 0", out_vld, out_src);
    end
    total++;
    if (req_rdy !== '0) begin bad++; $display("FAIL t6_async_rdy got=%h exp=0", req_rdy); end
    total++;
    if (crd_cnt !== {CH_NUM{3'd4}} || crd_ovf_err !== '0) begin
      bad++; $display("FAIL t6_async_crd cnt=%h ovf=%h exp cnt=all 4 ovf=0", crd_cnt, crd_ovf_err);
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (req_rdy !== {CH_NUM{3'b001}}) begin bad++; $display("FAIL t6_west_first got=%h exp=all 001", req_rdy); end
    step();
    total++;
    if (out_vld !== 8'hFF || out_src !== '0) begin
      bad++; $display("FAIL t6_post_out vld=%h src=%h exp vld=ff src=0", out_vld, out_src);
    end
    req_vld = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_west();
    test_round_robin();
    test_credit_exhaust();
    test_overflow();
    test_cfg_disable();
    test_reset_mid_traffic();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
